// File: rtl/hpdl_display_ctrl.sv
// Write scheduler for four chained HPDL-1414 displays: a 16-character shadow buffer with
// dirty bits, serviced round-robin as setup / strobe / hold bus cycles.
module hpdl_display_ctrl #(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       host_we,
   input  logic [3:0] host_addr,
   input  logic [6:0] host_data,
   input  logic       refresh_all,
   output logic [6:0] hpdl_d,
   output logic [1:0] hpdl_a,
   output logic [3:0] hpdl_wr_n,
   output logic       busy
);

   localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
   localparam cnt_t PULSE_LAST = cnt_t'(PULSE_CYC - 1);
   localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

   state_e      r_state;
   state_e      w_state_d;
   cnt_t        r_cnt;
   cnt_t        w_cnt_d;
   logic [15:0] r_dirty;
   logic [15:0] w_dirty_d;
   logic [6:0]  r_buf [16];
   logic [3:0]  r_ptr;
   logic [1:0]  r_tgt;
   logic [6:0]  r_d;
   logic [1:0]  r_a;
   logic [3:0]  r_wr_n;
   logic        r_busy;

   logic        w_found;
   logic [3:0]  w_sel;
   logic [3:0]  w_idx;
   logic        w_load;

   // Scan downward so the smallest offset from r_ptr is the one that sticks.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      w_idx   = r_ptr;
      for (int i = 15; i >= 0; i--) begin
         w_idx = r_ptr + 4'(i);
         if (r_dirty[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_dirty_d = r_dirty;
      w_load    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_state_d        = StSetup;
               w_cnt_d          = '0;
               w_load           = 1'b1;
               w_dirty_d[w_sel] = 1'b0;
            end
         end
         StSetup: begin
            if (r_cnt == SETUP_LAST) begin
               w_state_d = StStrobe;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + cnt_t'(1);
            end
         end
         StStrobe: begin
            if (r_cnt == PULSE_LAST) begin
               w_state_d = StHold;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + cnt_t'(1);
            end
         end
         StHold: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + cnt_t'(1);
            end
         end
         default: ;
      endcase
      // Host sets are applied last so they win over the service clear.
      if (refresh_all) w_dirty_d = '1;
      if (host_we) w_dirty_d[host_addr] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_dirty <= '1;
         r_ptr   <= 4'd0;
         r_tgt   <= 2'd0;
         r_d     <= 7'h00;
         r_a     <= 2'b00;
         r_wr_n  <= 4'b1111;
         r_busy  <= 1'b1;
         for (int i = 0; i < 16; i++) r_buf[i] <= 7'h20;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_dirty <= w_dirty_d;
         if (host_we) r_buf[host_addr] <= host_data;
         if (w_load) begin
            r_d   <= r_buf[w_sel];
            r_a   <= w_sel[1:0];
            r_tgt <= w_sel[3:2];
            r_ptr <= w_sel + 4'd1;
         end
         // Strobe is registered from the next state so the pin tracks STROBE exactly.
         r_wr_n <= (w_state_d == StStrobe) ? ~(4'b0001 << r_tgt) : 4'b1111;
         r_busy <= (w_state_d != StIdle) | (|w_dirty_d);
      end
   end

   assign hpdl_d    = r_d;
   assign hpdl_a    = r_a;
   assign hpdl_wr_n = r_wr_n;
   assign busy      = r_busy;

endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// Directed vector bench for hpdl_display_ctrl: default-timing instance driven from a vector
// table, plus a 3/4/2 parameter instance checked with a hand-written sequence.
module tb_hpdl_display_ctrl;

   typedef struct {
      logic       rst;
      logic       we;
      logic [3:0] addr;
      logic [6:0] data;
      logic       refresh;
      logic       en;
      logic       chk_bus;
      logic [6:0] d;
      logic [1:0] a;
      logic [3:0] wr_n;
      logic       busy;
      int         seq;
   } vec_t;

   logic       CLK;
   logic       RST, host_we, refresh_all;
   logic [3:0] host_addr;
   logic [6:0] host_data;
   logic [6:0] hpdl_d;
   logic [1:0] hpdl_a;
   logic [3:0] hpdl_wr_n;
   logic       busy;

   logic       p_rst, p_we, p_refresh;
   logic [3:0] p_addr;
   logic [6:0] p_data;
   logic [6:0] p_d;
   logic [1:0] p_a;
   logic [3:0] p_wr_n;
   logic       p_busy;

   int n_vec  = 0;
   int n_fail = 0;
   vec_t vq[$];

   hpdl_display_ctrl u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .refresh_all(refresh_all),
      .hpdl_d     (hpdl_d),
      .hpdl_a     (hpdl_a),
      .hpdl_wr_n  (hpdl_wr_n),
      .busy       (busy)
   );

   hpdl_display_ctrl #(
      .SETUP_CYC(3),
      .PULSE_CYC(4),
      .HOLD_CYC (2)
   ) u_dut_p (
      .CLK        (CLK),
      .RST        (p_rst),
      .host_we    (p_we),
      .host_addr  (p_addr),
      .host_data  (p_data),
      .refresh_all(p_refresh),
      .hpdl_d     (p_d),
      .hpdl_a     (p_a),
      .hpdl_wr_n  (p_wr_n),
      .busy       (p_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic void add(input int seq, input logic rst, input logic we,
                               input logic [3:0] addr, input logic [6:0] data,
                               input logic refresh, input logic en, input logic chk_bus,
                               input logic [6:0] d, input logic [1:0] a,
                               input logic [3:0] wr_n, input logic bsy);
      vec_t v;
      v.seq = seq; v.rst = rst; v.we = we; v.addr = addr; v.data = data;
      v.refresh = refresh; v.en = en; v.chk_bus = chk_bus; v.d = d; v.a = a;
      v.wr_n = wr_n; v.busy = bsy;
      vq.push_back(v);
   endfunction

   // Idle-input vectors with or without a bus check.
   function automatic void add_bus(input int seq, input logic [6:0] d, input logic [1:0] a,
                                   input logic [3:0] wr_n, input logic bsy);
      add(seq, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b1, 1'b1, d, a, wr_n, bsy);
   endfunction

   function automatic void add_nb(input int seq, input logic we, input logic [3:0] addr,
                                  input logic [6:0] data, input logic [3:0] wr_n,
                                  input logic bsy);
      add(seq, 1'b0, we, addr, data, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0, wr_n, bsy);
   endfunction

   // Full 16-character in-order pass starting from the selecting edge; 5 cycles each.
   function automatic void gen_run(input int seq, input logic [6:0] ch [16]);
      for (int k = 1; k <= 80; k++) begin
         int         i;
         int         p;
         logic [3:0] ix;
         logic [3:0] wr;
         i  = (k - 1) / 5;
         p  = (k - 1) % 5;
         ix = 4'(i);
         wr = (p == 1 || p == 2) ? ~(4'b0001 << ix[3:2]) : 4'b1111;
         add(seq, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b1, (p < 4), ch[i], ix[1:0], wr, (k != 80));
      end
   endfunction

   task automatic pchk(input string nm, input logic cb, input logic [6:0] d,
                       input logic [1:0] a, input logic [3:0] wr, input logic bsy);
      n_vec++;
      if (p_wr_n !== wr || p_busy !== bsy || (cb && (p_d !== d || p_a !== a))) begin
         n_fail++;
         $display("FAIL %s: got wr_n=%b busy=%b d=%h a=%b, want wr_n=%b busy=%b d=%h a=%b",
                  nm, p_wr_n, p_busy, p_d, p_a, wr, bsy, d, a);
      end
   endtask

   task automatic pstep(input logic we, input logic [3:0] addr, input logic [6:0] data);
      p_we = we; p_addr = addr; p_data = data;
      @(posedge CLK);
      #1;
   endtask

   logic [6:0] blank [16];
   logic [6:0] hello [16];

   initial begin
      string s;
      byte   b;
      RST = 1'b1; host_we = 1'b0; host_addr = 4'd0; host_data = 7'd0; refresh_all = 1'b0;
      p_rst = 1'b1; p_we = 1'b0; p_addr = 4'd0; p_data = 7'd0; p_refresh = 1'b0;

      s = "HELLO WORLD 1414";
      for (int i = 0; i < 16; i++) begin
         blank[i] = 7'h20;
         b = s[i];
         hello[i] = b[6:0];
      end

      // 1: reset state, then automatic blank of all 16 characters
      add(1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 1'b1, 1'b1, 7'h00, 2'b00, 4'b1111, 1'b1);
      add(1, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 1'b1, 1'b1, 7'h00, 2'b00, 4'b1111, 1'b1);
      gen_run(1, blank);

      // 2: single write, index 9 = 0x41
      add_nb (2, 1'b1, 4'd9, 7'h41, 4'b1111, 1'b1);
      add_bus(2, 7'h41, 2'b01, 4'b1111, 1'b1);
      add_bus(2, 7'h41, 2'b01, 4'b1011, 1'b1);
      add_bus(2, 7'h41, 2'b01, 4'b1011, 1'b1);
      add_bus(2, 7'h41, 2'b01, 4'b1111, 1'b1);
      add_nb (2, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b0);

      // 3: rewrite index 5 during its strobe; bus in flight is frozen
      add_nb (3, 1'b1, 4'd5, 7'h42, 4'b1111, 1'b1);
      add_bus(3, 7'h42, 2'b01, 4'b1111, 1'b1);
      add_bus(3, 7'h42, 2'b01, 4'b1101, 1'b1);
      add(3, 1'b0, 1'b1, 4'd5, 7'h43, 1'b0, 1'b1, 1'b1, 7'h42, 2'b01, 4'b1101, 1'b1);
      add_bus(3, 7'h42, 2'b01, 4'b1111, 1'b1);
      add_nb (3, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b1);
      add_bus(3, 7'h43, 2'b01, 4'b1111, 1'b1);
      add_bus(3, 7'h43, 2'b01, 4'b1101, 1'b1);
      add_bus(3, 7'h43, 2'b01, 4'b1101, 1'b1);
      add_bus(3, 7'h43, 2'b01, 4'b1111, 1'b1);
      add_nb (3, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b0);

      // 4: reset during strobe of display 2, blank restarts at index 0
      add_nb (4, 1'b1, 4'd8, 7'h55, 4'b1111, 1'b1);
      add_bus(4, 7'h55, 2'b00, 4'b1111, 1'b1);
      add_bus(4, 7'h55, 2'b00, 4'b1011, 1'b1);
      add(4, 1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 1'b1, 1'b1, 7'h00, 2'b00, 4'b1111, 1'b1);
      gen_run(4, blank);

      // 5: load "HELLO WORLD 1414", drain, then refresh_all rewrites it unchanged
      for (int i = 0; i < 16; i++)
         add(5, 1'b0, 1'b1, 4'(i), hello[i], 1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 4'd0, 1'b0);
      for (int i = 0; i < 70; i++)
         add(5, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 4'd0, 1'b0);
      add_nb(5, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b0);
      add(5, 1'b0, 1'b0, 4'd0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd0, 2'd0, 4'b1111, 1'b1);
      gen_run(5, hello);

      // 6: round-robin wrap, ptr = 14 with 3 and 15 dirty -> 15 then 3
      add_nb (6, 1'b1, 4'd13, 7'h4D, 4'b1111, 1'b1);
      add(6, 1'b0, 1'b1, 4'd3, 7'h33, 1'b0, 1'b1, 1'b1, 7'h4D, 2'b01, 4'b1111, 1'b1);
      add(6, 1'b0, 1'b1, 4'd15, 7'h3F, 1'b0, 1'b1, 1'b1, 7'h4D, 2'b01, 4'b0111, 1'b1);
      add_bus(6, 7'h4D, 2'b01, 4'b0111, 1'b1);
      add_bus(6, 7'h4D, 2'b01, 4'b1111, 1'b1);
      add_nb (6, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b1);
      add_bus(6, 7'h3F, 2'b11, 4'b1111, 1'b1);
      add_bus(6, 7'h3F, 2'b11, 4'b0111, 1'b1);
      add_bus(6, 7'h3F, 2'b11, 4'b0111, 1'b1);
      add_bus(6, 7'h3F, 2'b11, 4'b1111, 1'b1);
      add_nb (6, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b1);
      add_bus(6, 7'h33, 2'b11, 4'b1111, 1'b1);
      add_bus(6, 7'h33, 2'b11, 4'b1110, 1'b1);
      add_bus(6, 7'h33, 2'b11, 4'b1110, 1'b1);
      add_bus(6, 7'h33, 2'b11, 4'b1111, 1'b1);
      add_nb (6, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b0);

      // 7: host write to the index being selected -> serviced twice
      add_nb (7, 1'b1, 4'd6, 7'h36, 4'b1111, 1'b1);
      add(7, 1'b0, 1'b1, 4'd6, 7'h37, 1'b0, 1'b1, 1'b1, 7'h36, 2'b10, 4'b1111, 1'b1);
      add_bus(7, 7'h36, 2'b10, 4'b1101, 1'b1);
      add_bus(7, 7'h36, 2'b10, 4'b1101, 1'b1);
      add_bus(7, 7'h36, 2'b10, 4'b1111, 1'b1);
      add_nb (7, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b1);
      add_bus(7, 7'h37, 2'b10, 4'b1111, 1'b1);
      add_bus(7, 7'h37, 2'b10, 4'b1101, 1'b1);
      add_bus(7, 7'h37, 2'b10, 4'b1101, 1'b1);
      add_bus(7, 7'h37, 2'b10, 4'b1111, 1'b1);
      add_nb (7, 1'b0, 4'd0, 7'd0, 4'b1111, 1'b0);

      for (int i = 0; i < vq.size(); i++) begin
         vec_t v;
         v = vq[i];
         RST = v.rst; host_we = v.we; host_addr = v.addr; host_data = v.data;
         refresh_all = v.refresh;
         @(posedge CLK);
         #1;
         if (v.en) begin
            n_vec++;
            if (hpdl_wr_n !== v.wr_n || busy !== v.busy ||
                (v.chk_bus && (hpdl_d !== v.d || hpdl_a !== v.a))) begin
               n_fail++;
               $display("FAIL seq%0d vec%0d: got wr_n=%b busy=%b d=%h a=%b, want wr_n=%b busy=%b d=%h a=%b",
                        v.seq, i, hpdl_wr_n, busy, hpdl_d, hpdl_a, v.wr_n, v.busy, v.d, v.a);
            end
         end
      end
      host_we = 1'b0; refresh_all = 1'b0;

      // 8: parameters 3/4/2, first blank character then a single write
      pchk("p_reset", 1'b1, 7'h00, 2'b00, 4'b1111, 1'b1);
      p_rst = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         int p;
         p = k - 1;
         pstep(1'b0, 4'd0, 7'd0);
         if (p < 3)       pchk("p_blank_setup", 1'b1, 7'h20, 2'b00, 4'b1111, 1'b1);
         else if (p < 7)  pchk("p_blank_strobe", 1'b1, 7'h20, 2'b00, 4'b1110, 1'b1);
         else if (p < 9)  pchk("p_blank_hold", 1'b1, 7'h20, 2'b00, 4'b1111, 1'b1);
         else if (p == 9) pchk("p_blank_idle", 1'b0, 7'h00, 2'b00, 4'b1111, 1'b1);
         else             pchk("p_blank_next", 1'b1, 7'h20, 2'b01, 4'b1111, 1'b1);
      end
      begin
         int n;
         n = 0;
         while (p_busy !== 1'b0 && n < 400) begin
            pstep(1'b0, 4'd0, 7'd0);
            n++;
         end
         n_vec++;
         if (n >= 400) begin
            n_fail++;
            $display("FAIL p_drain: busy still %b after %0d cycles, want 0", p_busy, n);
         end
      end
      pstep(1'b1, 4'd6, 7'h41);
      pchk("p_wr_accept", 1'b0, 7'h00, 2'b00, 4'b1111, 1'b1);
      for (int j = 1; j <= 10; j++) begin
         pstep(1'b0, 4'd0, 7'd0);
         if (j <= 3)      pchk("p_setup", 1'b1, 7'h41, 2'b10, 4'b1111, 1'b1);
         else if (j <= 7) pchk("p_strobe", 1'b1, 7'h41, 2'b10, 4'b1101, 1'b1);
         else if (j <= 9) pchk("p_hold", 1'b1, 7'h41, 2'b10, 4'b1111, 1'b1);
         else             pchk("p_idle", 1'b0, 7'h00, 2'b00, 4'b1111, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/hpdl_display_ctrl.md
# hpdl_display_ctrl

Write scheduler for a chain of four HPDL-1414 displays (16 characters) sharing one 7-bit data bus, a 2-bit digit address and four active-low write strobes. It holds a 16-entry shadow character buffer with per-character dirty bits and sequences each dirty character onto the shared bus as one complete write cycle, with setup, strobe and hold widths set by parameters. It sits between the host logic (the text source) and the HPDL pins, replacing any direct pin driving.

## Interface
- SETUP_CYC, 1, cycles data/address are stable with all strobes high before the strobe (≥1)
- PULSE_CYC, 2, cycles the selected strobe is held low (≥1)
- HOLD_CYC, 1, cycles data/address are held after the strobe rises (≥1)

- CLK  in  1  system clock (12 MHz on board); single clock domain
- RST  in  1  synchronous reset, active-high
- host_we  in  1  write one character into the shadow buffer this cycle
- host_addr  in  4  character index; [3:2] = display 0..3, [1:0] = digit address
- host_data  in  7  character code (HPDL set 0x20–0x5F; other codes passed through unchanged)
- refresh_all  in  1  pulse: mark all 16 characters dirty
- hpdl_d  out  7  display data bus
- hpdl_a  out  2  digit address, hpdl_a = index[1:0]
- hpdl_wr_n  out  4  active-low write strobes; bit k strobes display k = index[3:2]
- busy  out  1  high while any dirty bit is set or a write cycle is in progress

## Operation
- Host port is always ready. host_we updates buf[host_addr] and sets dirty[host_addr] at the clock edge ending that cycle.
- refresh_all sets all dirty bits at the same edge. It may coincide with host_we; both take effect.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any dirty bit is set, select the first dirty index at or after ptr, wrapping 15→0. On the same edge:
  - latch hpdl_d = buf[sel] and hpdl_a = sel[1:0], and register sel[3:2] as the target display;
  - clear dirty[sel];
  - set ptr = sel+1 (mod 16);
  - go to SETUP.
- Dirty-clear conflict: if host_we targets sel in that same cycle, the set wins. dirty[sel] stays 1, and the new character is written in a later cycle.
- Bus contents are frozen from entry to SETUP until the return to IDLE. Host writes during a cycle change only the buffer and dirty bits, never the bus in flight.
- SETUP: hold for SETUP_CYC cycles, then go to STROBE.
- STROBE: hpdl_wr_n[target] = 0 and the other three bits = 1, for PULSE_CYC cycles; then go to HOLD.
- HOLD: all strobes high for HOLD_CYC cycles, then go to IDLE.
- Per-character period is 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, which is 5 at the defaults.
- Only one strobe bit is ever low, and only in STROBE.
- busy = (state ≠ IDLE) | (|dirty).
- Width rules:
  - phase counter sized for max(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  - ptr is 4 bits and wraps naturally.

## Timing
- Reset values:
  - hpdl_wr_n = 4'b1111, hpdl_d = 7'h00, hpdl_a = 2'b00;
  - state IDLE, ptr 0;
  - every buf entry = 7'h20 (space), all dirty = 1, so busy = 1;
  - effect: the chain is blanked automatically after reset.
- RST asserted mid-cycle, including during STROBE: strobes are high from the next edge. The cycle is abandoned with no partial second strobe, and the full reset state applies.
- Latency: host_we in cycle t, with the FSM idle and no other dirty bits:
  - t+1: IDLE selects;
  - t+2: hpdl_d/hpdl_a valid;
  - t+2+SETUP_CYC: strobe low (t+3 at defaults);
  - strobe rises at t+2+SETUP_CYC+PULSE_CYC.
- All outputs are registered. There are no combinational paths from inputs to pins.

## Test plan
- Reset release, defaults: 16 write cycles, indices 0..15 in order, each 5 cycles.
  - each cycle: hpdl_d = 0x20;
  - hpdl_wr_n walks 1110 (×4), 1101, 1011, 0111;
  - busy drops 1 cycle after the last HOLD.
- Idle, write index 9 = 0x41 at cycle t:
  - hpdl_d = 0x41 and hpdl_a = 01 from t+2;
  - hpdl_wr_n = 1011 during t+3..t+4;
  - exactly one strobe.
- Write index 5 = 0x42, then index 5 = 0x43 during its STROBE:
  - two strobes of display 1;
  - first carries 0x42 unchanged on the bus, second carries 0x43.
- Round-robin wrap: ptr = 14 with indices 3 and 15 dirty: service order 15 then 3.
- Dirty-clear conflict: host_we to index sel in the same cycle IDLE selects sel: that index is serviced twice.
- Reset during STROBE of display 2:
  - hpdl_wr_n = 1111 one edge after RST;
  - the blank sequence restarts at index 0.
- refresh_all while idle with buffer "HELLO...": all 16 characters rewritten with unchanged data.
- Parameters 3/4/2: strobe width 4 cycles, data stable 3 cycles before the strobe and 2 after.
